wb_trace_buffer: RTL and testbench
==================================

// Module: wb_trace_buffer
// PURPOSE
// - Synthesizable retirement tracer downstream of the mips pipeline's MEM/WB stages.
// - Captures architectural side effects: register writebacks and data-memory stores.
// - Tags each event with a cycle stamp and buffers it in a FIFO.
// - Drains the FIFO over a valid/ready stream to the debug/UART link.
// PARAMETERS
// - DEPTH  16  FIFO entries; power of two, >= 4.
// - CNT_W  16  width of the dropped-event counter.
// PORTS
// - clk          in   1   system clock
// - reset        in   1   synchronous, active-high
// - trace_en     in   1   1 = capture events and advance the stamp counter
// - flush        in   1   synchronous clear of the FIFO; counters are kept
// - wb_reg_write in   1   WB-stage RegWrite
// - wb_write_reg in   5   WB destination register
// - wb_write_data in  32  WB writeback value
// - mem_mem_write in  1   MEM-stage MemWrite
// - mem_alu_result in 32  MEM-stage byte address
// - mem_write_data in 32  MEM-stage store data
// - out_valid    out  1   head entry available
// - out_ready    in   1   consumer accepts the head entry
// - out_data     out  64  {kind[63:62], stamp[61:46], addr[45:32], data[31:0]}
// - level        out  $clog2(DEPTH)+1   current occupancy
// - dropped      out  CNT_W   events lost because the FIFO was full; saturates
// BEHAVIOUR
// - Reset values: out_valid=0, out_data=0, level=0, dropped=0, stamp=0, FIFO empty.
// - Stamp counter:
//   - 16 bits; increments every cycle while trace_en=1.
//   - Wraps 0xFFFF->0x0000.
//   - An event's stamp is the counter value in the capture cycle.
// - Register event:
//   - Fires when trace_en & wb_reg_write & (wb_write_reg!=0).
//   - kind=KIND_REG (2'b01); addr={9'b0, wb_write_reg}; data=wb_write_data.
// - Store event:
//   - Fires when trace_en & mem_mem_write.
//   - kind=KIND_MEM (2'b10); addr=mem_alu_result[15:2] (word index); data=mem_write_data.
// - Pushes:
//   - Up to 2 pushes per cycle.
//   - When both events fire, REG is ordered before MEM: REG in slot wr_ptr, MEM in slot wr_ptr+1.
// - Capacity check:
//   - free = DEPTH - level + (out_valid & out_ready).
//   - A pop in the same cycle frees a slot for that cycle's push.
//   - 2 events, free>=2: both pushed.
//   - 2 events, free==1: REG pushed, MEM dropped.
//   - free==0: all events dropped.
//   - Each dropped event adds 1 to dropped, saturating at all-ones; 2 drops in one cycle add 2.
// - Latency:
//   - An event captured in cycle N is visible on out_data/out_valid in cycle N+1 when the FIFO was empty.
//   - There is no bypass from input to output.
// - Handshake:
//   - Pop occurs when out_valid & out_ready.
//   - out_data is stable while out_valid=1 and out_ready=0.
//   - out_data is don't-care when out_valid=0 but must not contain X after reset.
// - Pointers:
//   - $clog2(DEPTH) bits; wrap modulo DEPTH.
//   - level is the registered count and always equals pushes minus pops.
// - flush:
//   - Pointers and level go to 0; the next cycle has out_valid=0.
//   - Events in the flush cycle are discarded and are not counted as dropped.
//   - Stamp and dropped keep their values.
// - trace_en=0:
//   - No captures; the stamp counter holds.
//   - The FIFO still drains.
// - Mid-operation reset: a reset in any cycle overrides flush, pushes and pop.
// STRUCTURE
// - Package trace_pkg holds:
//   - KIND_REG and KIND_MEM codes.
//   - Field offsets and widths: KIND_LSB=62, STAMP_LSB=46, ADDR_LSB=32, ENTRY_W=64.
//   - A function pack_entry(kind, stamp, addr, data).
// - Sub-module trace_fifo_2w:
//   - Two-write, one-read, show-ahead register-array FIFO.
//   - Ports: push0/push1 with data, pop, level.
//   - Top level holds event detection, stamp counter, admission logic and the dropped counter.
// TESTING
// - Single event: reset, trace_en=1; one cycle with wb_reg_write=1, reg=5, data=0x1234, stamp=3.
//   - Next cycle: out_valid=1, out_data={01,0x0003,0x0005,0x00001234}.
//   - After out_ready=1: level=0.
// - Dual event: REG (reg 2, 0x7) and MEM (address 100, data 0x2A) fire together.
//   - Pops in order: REG entry first, then MEM entry with addr=25.
// - $0 filter and disable:
//   - A write to reg 0 produces no entry.
//   - With trace_en=0, a store produces no entry and the stamp holds.
// - Overflow, DEPTH=16, out_ready=0:
//   - 16 REG events fill the FIFO.
//   - A 17th cycle with both events gives dropped=2 and level=16.
//   - A cycle with 1 free slot plus both events pushes REG only, dropped+1.
//   - A full FIFO with pop and push in the same cycle keeps level=16, dropped unchanged.
// - Backpressure and wrap:
//   - Push 40 events with random out_ready.
//   - All 40 pop in order, out_data is stable while stalled, and pointers wrap.
// - Flush and reset:
//   - Flush with level=7 plus a simultaneous event: level=0, out_valid=0 next cycle, dropped unchanged.
//   - Reset asserted mid-drain: every output returns to its reset value next cycle.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared entry kinds, field layout and packing helper for the retirement tracer
package trace_pkg;

    localparam int ENTRY_W   = 64;
    localparam int KIND_LSB  = 62;
    localparam int STAMP_LSB = 46;
    localparam int ADDR_LSB  = 32;
    localparam int KIND_W    = ENTRY_W - KIND_LSB;
    localparam int STAMP_W   = KIND_LSB - STAMP_LSB;
    localparam int ADDR_W    = STAMP_LSB - ADDR_LSB;
    localparam int DATA_W    = ADDR_LSB;

    typedef enum logic [KIND_W-1:0] {
        KIND_NONE = 2'b00,
        KIND_REG  = 2'b01,
        KIND_MEM  = 2'b10
    } kind_e;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input kind_e              kind,
        input logic [STAMP_W-1:0] stamp,
        input logic [ADDR_W-1:0]  addr,
        input logic [DATA_W-1:0]  data
    );
        return {kind, stamp, addr, data};
    endfunction

endpackage

// File: rtl/trace_fifo_2w.sv
// rtl/trace_fifo_2w.sv - two-write one-read show-ahead register-array FIFO
module trace_fifo_2w #(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     push0_i,
    input  logic [W-1:0]             data0_i,
    input  logic                     push1_i,
    input  logic [W-1:0]             data1_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rd_data_o,
    output logic                     rd_valid_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
    logic [PW:0]   level_q, level_d;
    logic          do_pop;

    assign rd_valid_o = (level_q != '0);
    // Masking keeps the unreset array from ever showing X on the output.
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o    = level_q;
    assign do_pop     = pop_i & rd_valid_o;
    assign wr_ptr_p1  = wr_ptr_q + 1'b1;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        level_d  = level_q + (PW+1)'(push0_i) + (PW+1)'(push1_i) - (PW+1)'(do_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && !flush_i) begin
            if (push0_i) mem_q[wr_ptr_q]  <= data0_i;
            if (push1_i) mem_q[wr_ptr_p1] <= data1_i;
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - stamps register writebacks and stores, buffers them, drains over valid/ready
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic                     flush,
    input  logic                     wb_reg_write,
    input  logic [4:0]               wb_write_reg,
    input  logic [31:0]              wb_write_data,
    input  logic                     mem_mem_write,
    input  logic [31:0]              mem_alu_result,
    input  logic [31:0]              mem_write_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ENTRY_W-1:0]       out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         dropped
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int FW = LW + 1;

    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic [CNT_W-1:0]   dropped_q, dropped_d;
    logic [CNT_W:0]     drop_sum;
    logic               reg_ev, mem_ev, pop;
    logic [FW-1:0]      free;
    logic               push0, push1;
    logic [ENTRY_W-1:0] data0, reg_entry, mem_entry;
    logic [1:0]         n_drop;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{mem_alu_result[31:16], mem_alu_result[1:0]};

    assign reg_ev    = trace_en & wb_reg_write & (wb_write_reg != 5'd0);
    assign mem_ev    = trace_en & mem_mem_write;
    assign pop       = out_valid & out_ready;
    assign reg_entry = pack_entry(KIND_REG, stamp_q, {9'b0, wb_write_reg}, wb_write_data);
    assign mem_entry = pack_entry(KIND_MEM, stamp_q, mem_alu_result[15:2], mem_write_data);
    // A same-cycle pop frees its slot for this cycle's pushes.
    assign free      = FW'(DEPTH) - {1'b0, level} + FW'(pop);

    always_comb begin
        push0  = 1'b0;
        push1  = 1'b0;
        data0  = reg_entry;
        n_drop = 2'd0;
        if (!flush) begin
            unique case ({reg_ev, mem_ev})
                2'b11: begin
                    if (free >= FW'(2)) begin
                        push0 = 1'b1;
                        push1 = 1'b1;
                    end else if (free == FW'(1)) begin
                        push0  = 1'b1;
                        n_drop = 2'd1;
                    end else begin
                        n_drop = 2'd2;
                    end
                end
                2'b10, 2'b01: begin
                    if (mem_ev) data0 = mem_entry;
                    if (free != '0) push0  = 1'b1;
                    else            n_drop = 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stamp_d   = trace_en ? stamp_q + 1'b1 : stamp_q;
        drop_sum  = {1'b0, dropped_q} + (CNT_W+1)'(n_drop);
        dropped_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stamp_q   <= '0;
            dropped_q <= '0;
        end else begin
            stamp_q   <= stamp_d;
            dropped_q <= dropped_d;
        end
    end

    assign dropped = dropped_q;

    trace_fifo_2w #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk_i      (clk),
        .reset_i    (reset),
        .flush_i    (flush),
        .push0_i    (push0),
        .data0_i    (data0),
        .push1_i    (push1),
        .data1_i    (mem_entry),
        .pop_i      (pop),
        .rd_data_o  (out_data),
        .rd_valid_o (out_valid),
        .level_o    (level)
    );

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - directed self-checking bench for wb_trace_buffer
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        reset, trace_en, flush;
    logic        wb_reg_write, mem_mem_write, out_ready;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data, mem_alu_result, mem_write_data;
    logic        out_valid;
    logic [63:0] out_data;
    logic [4:0]  level;
    logic [15:0] dropped;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_stamp = 16'd0;

    always #5 clk = ~clk;

    wb_trace_buffer #(.DEPTH(16), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .trace_en       (trace_en),
        .flush          (flush),
        .wb_reg_write   (wb_reg_write),
        .wb_write_reg   (wb_write_reg),
        .wb_write_data  (wb_write_data),
        .mem_mem_write  (mem_mem_write),
        .mem_alu_result (mem_alu_result),
        .mem_write_data (mem_write_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .level          (level),
        .dropped        (dropped)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) exp_stamp = 16'd0;
        else if (trace_en) exp_stamp = exp_stamp + 16'd1;
        #1;
    endtask

    task automatic no_events();
        wb_reg_write  = 1'b0;
        mem_mem_write = 1'b0;
    endtask

    function automatic logic [63:0] ent(input logic [1:0] k, input logic [15:0] s,
                                        input logic [13:0] a, input logic [31:0] d);
        return {k, s, a, d};
    endfunction

    initial begin : main
        logic [15:0] s;
        logic [63:0] q[$];
        logic [63:0] new_e, prev_data;
        logic        do_push, do_pop, stall_prev;
        int          pushed, popped, cyc;

        reset = 1'b1; trace_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
        wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0;
        mem_mem_write = 1'b0; mem_alu_result = '0; mem_write_data = '0;
        #1;
        tick(); tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_level", level, 0);
        check("rst_dropped", dropped, 0);

        // single REG event captured at stamp 3
        reset = 1'b0; trace_en = 1'b1;
        tick(); tick(); tick();
        wb_reg_write = 1'b1; wb_write_reg = 5'd5; wb_write_data = 32'h1234;
        tick();
        no_events();
        check("single_valid", out_valid, 1);
        check("single_data", out_data, {2'b01, 16'h0003, 14'h0005, 32'h00001234});
        check("single_level1", level, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_level0", level, 0);
        check("single_empty", out_valid, 0);

        // dual event, REG ordered before MEM
        s = exp_stamp;
        wb_reg_write = 1'b1; wb_write_reg = 5'd2; wb_write_data = 32'h7;
        mem_mem_write = 1'b1; mem_alu_result = 32'd100; mem_write_data = 32'h2A;
        tick();
        no_events();
        check("dual_level", level, 2);
        check("dual_first", out_data, ent(2'b01, s, 14'd2, 32'h7));
        out_ready = 1'b1;
        tick();
        check("dual_second", out_data, ent(2'b10, s, 14'd25, 32'h2A));
        tick();
        out_ready = 1'b0;
        check("dual_drained", level, 0);

        // $0 filter and trace disable
        wb_reg_write = 1'b1; wb_write_reg = 5'd0; wb_write_data = 32'hDEAD;
        tick();
        no_events();
        check("reg0_level", level, 0);
        check("reg0_valid", out_valid, 0);
        s = exp_stamp;
        trace_en = 1'b0;
        mem_mem_write = 1'b1; mem_alu_result = 32'h40; mem_write_data = 32'hBEEF;
        tick(); tick();
        no_events();
        check("dis_level", level, 0);
        trace_en = 1'b1;
        wb_reg_write = 1'b1; wb_write_reg = 5'd1; wb_write_data = 32'h55;
        tick();
        no_events();
        check("dis_stamp_hold", out_data, ent(2'b01, s, 14'd1, 32'h55));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // overflow
        for (int i = 0; i < 16; i++) begin
            wb_reg_write = 1'b1; wb_write_reg = 5'(i + 1); wb_write_data = 32'(i);
            tick();
        end
        no_events();
        check("ovf_full_level", level, 16);
        check("ovf_full_dropped", dropped, 0);
        wb_reg_write = 1'b1; mem_mem_write = 1'b1; mem_write_data = 32'h99;
        tick();
        no_events();
        check("ovf_both_level", level, 16);
        check("ovf_both_dropped", dropped, 2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ovf_pop_level", level, 15);
        check("ovf_pop_head", out_data[31:0], 1);
        wb_reg_write = 1'b1; wb_write_data = 32'h77; mem_mem_write = 1'b1;
        tick();
        no_events();
        check("ovf_one_free_level", level, 16);
        check("ovf_one_free_dropped", dropped, 3);
        out_ready = 1'b1;
        wb_reg_write = 1'b1; wb_write_data = 32'h88;
        tick();
        no_events();
        check("ovf_pushpop_level", level, 16);
        check("ovf_pushpop_dropped", dropped, 3);
        check("ovf_pushpop_head", out_data[31:0], 2);
        for (int i = 0; i < 9; i++) tick();
        out_ready = 1'b0;
        check("flush_pre_level", level, 7);

        // flush with simultaneous event
        flush = 1'b1;
        wb_reg_write = 1'b1; wb_write_reg = 5'd3; wb_write_data = 32'h33;
        tick();
        flush = 1'b0;
        no_events();
        check("flush_level", level, 0);
        check("flush_valid", out_valid, 0);
        check("flush_dropped", dropped, 3);

        // backpressure with wrap
        pushed = 0; popped = 0; cyc = 0; stall_prev = 1'b0; prev_data = '0;
        while (popped < 40 && cyc < 2000) begin
            check("bp_valid", out_valid, q.size() != 0);
            check("bp_level", level, q.size());
            if (out_valid && q.size() != 0) check("bp_data", out_data, q[0]);
            if (stall_prev) check("bp_stable", out_data, prev_data);
            out_ready     = 1'($urandom_range(0, 1));
            do_push       = (pushed < 40) && (q.size() < 15);
            wb_reg_write  = do_push;
            wb_write_reg  = 5'((pushed % 31) + 1);
            wb_write_data = 32'h1000 + 32'(pushed);
            do_pop        = out_valid && out_ready;
            stall_prev    = out_valid && !out_ready;
            prev_data     = out_data;
            new_e         = ent(2'b01, exp_stamp, {9'b0, wb_write_reg}, wb_write_data);
            tick();
            if (do_pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (do_push) begin
                q.push_back(new_e);
                pushed++;
            end
            cyc++;
        end
        no_events();
        check("bp_all_popped", popped, 40);
        check("bp_dropped", dropped, 3);

        // reset mid-drain
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_reg_write = 1'b1; wb_write_reg = 5'd4; wb_write_data = 32'(i);
            tick();
        end
        no_events();
        out_ready = 1'b1;
        tick();
        reset = 1'b1;
        wb_reg_write = 1'b1;
        tick();
        no_events();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_dropped", dropped, 0);
        reset = 1'b0; out_ready = 1'b0;
        wb_reg_write = 1'b1; wb_write_reg = 5'd9; wb_write_data = 32'hABCD;
        tick();
        no_events();
        check("mid_rst_stamp0", out_data, {2'b01, 16'h0000, 14'd9, 32'h0000ABCD});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
